instr_encoder: RTL and testbench

Sequential RISC-V instruction encoder and instruction-memory loader. It accepts decoded instruction commands over a valid/ready handshake and packs each into a 32-bit RV32I machine word; this is the inverse of the control-path opcode decoder and sign extender. It writes the words to consecutive instruction-memory addresses and reports completion. It sits between the host/command path and the core's instruction memory, and is used to build test programs and kernels on-chip.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/imm_packer.sv | 56 +++++
 rtl/instr_encoder.sv | 185 ++++++++++++++++++
 tb/tb_instr_encoder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32I definitions for the control path and the
// instruction encoder.
//   instr_kind_t  - decoded instruction kinds accepted by instr_encoder
//   imm_src_t     - immediate format selector (shared with the sign extender)
//   OP_*          - major opcode constants
//   enc_state_t   - instr_encoder FSM states
package riscv_pkg;

    typedef enum logic [2:0] {
        KIND_LW    = 3'd0,
        KIND_SW    = 3'd1,
        KIND_RTYPE = 3'd2,
        KIND_BEQ   = 3'd3,
        KIND_ITYPE = 3'd4,
        KIND_JAL   = 3'd5,
        KIND_LUI   = 3'd6
    } instr_kind_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCEPT = 2'd1,
        ST_WRITE  = 2'd2
    } enc_state_t;

endpackage

// File: rtl/imm_packer.sv
// imm_packer: inverse of the sign extender. Scatters a signed immediate into
// the bit positions of a 32-bit instruction word for the selected format and
// flags immediates that the format cannot represent.
//   imm       in  32  byte offset / immediate
//   src       in  3   immediate format (imm_src_t)
//   bits      out 32  immediate bits at their word positions, all else zero
//   range_err out 1   immediate not representable in this format
module imm_packer
    import riscv_pkg::*;
(
    input  logic signed [31:0] imm,
    input  imm_src_t           src,
    output logic        [31:0] bits,
    output logic               range_err
);

    always_comb begin
        bits      = '0;
        range_err = 1'b0;
        case (src)
            IMM_I: begin
                bits[31:20] = imm[11:0];
                range_err   = (imm[31:11] != {21{imm[11]}});
            end
            IMM_S: begin
                bits[31:25] = imm[11:5];
                bits[11:7]  = imm[4:0];
                range_err   = (imm[31:11] != {21{imm[11]}});
            end
            IMM_B: begin
                bits[31]    = imm[12];
                bits[30:25] = imm[10:5];
                bits[11:8]  = imm[4:1];
                bits[7]     = imm[11];
                // Branch targets are halfword aligned; bit 0 has no encoding.
                range_err   = (imm[31:12] != {20{imm[12]}}) || imm[0];
            end
            IMM_J: begin
                bits[31]    = imm[20];
                bits[30:21] = imm[10:1];
                bits[20]    = imm[11];
                bits[19:12] = imm[19:12];
                range_err   = (imm[31:20] != {12{imm[20]}}) || imm[0];
            end
            IMM_U: begin
                bits[31:12] = imm[31:12];
                range_err   = |imm[11:0];
            end
            default: begin
                bits      = '0;
                range_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded instruction commands into RV32I words and
// writes them to consecutive instruction-memory word addresses.
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  begin a program load at BASE_ADDR (IDLE only)
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_kind_i .. cmd_last_i command fields, cmd_last_i marks the final one
//   mem_we_o/mem_addr_o/mem_wdata_o/mem_gnt_i  memory write, held until grant
//   busy_o                   FSM not IDLE
//   done_o                   one-cycle pulse after the program is retired
//   err_o                    sticky illegal-command flag, cleared by start_i
//   count_o                  words written since start
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [2:0]        cmd_kind_i,
    input  logic [4:0]        cmd_rd_i,
    input  logic [4:0]        cmd_rs1_i,
    input  logic [4:0]        cmd_rs2_i,
    input  logic [2:0]        cmd_funct3_i,
    input  logic [6:0]        cmd_funct7_i,
    input  logic signed [31:0] cmd_imm_i,
    input  logic              cmd_last_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [ADDR_W:0]   count_o
);

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W:0]   FULL = {1'b1, {ADDR_W{1'b0}}};

    enc_state_t        state, state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   count;
    logic [31:0]       wdata;
    logic              last_q;
    logic              err_q;
    logic              done_q;

    imm_src_t          imm_src;
    logic [31:0]       imm_bits;
    logic              imm_err;
    logic [31:0]       word;
    logic              illegal;
    logic              fire;
    logic              take;
    logic              is_shift;

    imm_packer u_imm_packer (
        .imm       (cmd_imm_i),
        .src       (imm_src),
        .bits      (imm_bits),
        .range_err (imm_err)
    );

    // Word assembly: every field a format does not use stays zero.
    always_comb begin
        imm_src  = IMM_I;
        word     = '0;
        illegal  = 1'b0;
        is_shift = (cmd_funct3_i == 3'b001) || (cmd_funct3_i == 3'b101);
        case (cmd_kind_i)
            KIND_LW: begin
                imm_src = IMM_I;
                word    = imm_bits | {12'd0, cmd_rs1_i, F3_WORD, cmd_rd_i, OP_LOAD};
                illegal = imm_err;
            end
            KIND_SW: begin
                imm_src = IMM_S;
                word    = imm_bits | {7'd0, cmd_rs2_i, cmd_rs1_i, F3_WORD, 5'd0, OP_STORE};
                illegal = imm_err;
            end
            KIND_RTYPE: begin
                word = {cmd_funct7_i, cmd_rs2_i, cmd_rs1_i, cmd_funct3_i, cmd_rd_i, OP_OP};
            end
            KIND_BEQ: begin
                imm_src = IMM_B;
                word    = imm_bits | {7'd0, cmd_rs2_i, cmd_rs1_i, F3_BEQ, 5'd0, OP_BRANCH};
                illegal = imm_err;
            end
            KIND_ITYPE: begin
                imm_src = IMM_I;
                if (is_shift) begin
                    // Shifts carry funct7 in imm[11:5] and a 5-bit shamt.
                    word    = {cmd_funct7_i, cmd_imm_i[4:0], cmd_rs1_i, cmd_funct3_i,
                               cmd_rd_i, OP_OPIMM};
                    illegal = |cmd_imm_i[31:5];
                end else begin
                    word    = imm_bits | {12'd0, cmd_rs1_i, cmd_funct3_i, cmd_rd_i, OP_OPIMM};
                    illegal = imm_err;
                end
            end
            KIND_JAL: begin
                imm_src = IMM_J;
                word    = imm_bits | {20'd0, cmd_rd_i, OP_JAL};
                illegal = imm_err;
            end
            KIND_LUI: begin
                imm_src = IMM_U;
                word    = imm_bits | {20'd0, cmd_rd_i, OP_LUI};
                illegal = imm_err;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign fire = cmd_valid_i && (state == ST_ACCEPT);
    // A full memory turns an otherwise legal command into a dropped one.
    assign take = fire && !illegal && (count != FULL);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start_i) state_nxt = ST_ACCEPT;
            ST_ACCEPT: begin
                if (take)                   state_nxt = ST_WRITE;
                else if (fire && cmd_last_i) state_nxt = ST_IDLE;
            end
            ST_WRITE:  if (mem_gnt_i) state_nxt = last_q ? ST_IDLE : ST_ACCEPT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Decoded from the state register so reset drops the write request
    // without waiting for a clock.
    always_comb begin
        cmd_ready_o = (state == ST_ACCEPT);
        mem_we_o    = (state == ST_WRITE);
        busy_o      = (state != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr    <= BASE;
            count  <= '0;
            wdata  <= '0;
            last_q <= 1'b0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == ST_IDLE && start_i) begin
                ptr   <= BASE;
                count <= '0;
                err_q <= 1'b0;
            end
            if (take) begin
                wdata  <= word;
                last_q <= cmd_last_i;
            end else if (fire) begin
                err_q  <= 1'b1;
                done_q <= cmd_last_i;
            end
            if (state == ST_WRITE && mem_gnt_i) begin
                ptr    <= ptr + ADDR_W'(1);
                count  <= count + (ADDR_W + 1)'(1);
                done_q <= last_q;
            end
        end
    end

    assign mem_addr_o  = ptr;
    assign mem_wdata_o = wdata;
    assign err_o       = err_q;
    assign done_o      = done_q;
    assign count_o     = count;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder built with ADDR_W=2 so the memory-full
// boundary is reachable with a handful of commands.
module tb_instr_encoder;
  import riscv_pkg::*;

  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_kind = '0;
  logic [4:0]    cmd_rd = '0;
  logic [4:0]    cmd_rs1 = '0;
  logic [4:0]    cmd_rs2 = '0;
  logic [2:0]    cmd_funct3 = '0;
  logic [6:0]    cmd_funct7 = '0;
  logic [31:0]   cmd_imm = '0;
  logic          cmd_last = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          busy;
  logic          done;
  logic          err;
  logic [AW:0]   count;

  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_kind_i   (cmd_kind),
    .cmd_rd_i     (cmd_rd),
    .cmd_rs1_i    (cmd_rs1),
    .cmd_rs2_i    (cmd_rs2),
    .cmd_funct3_i (cmd_funct3),
    .cmd_funct7_i (cmd_funct7),
    .cmd_imm_i    (cmd_imm),
    .cmd_last_i   (cmd_last),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_gnt_i    (mem_gnt),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .count_o      (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [2:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input logic last);
    int n = 0;
    cmd_kind = kind; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    cmd_funct3 = f3; cmd_funct7 = f7; cmd_imm = imm; cmd_last = last;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 20) begin
      tick();
      n++;
    end
    n_total++;
    if (n >= 20) begin
      n_fail++;
      $error("FAIL ready_wait: cmd_ready not seen within %0d cycles", n);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] addr, input logic [31:0] data, input int hold);
    int n = 0;
    while (!mem_we && n < 20) begin
      tick();
      n++;
    end
    n_total++;
    if (n >= 20) begin
      n_fail++;
      $error("FAIL we_wait: mem_we not seen within %0d cycles", n);
    end
    chk("addr", mem_addr, addr);
    chk("wdata", mem_wdata, data);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("stall_we", mem_we, 1'b1);
      chk("stall_addr", mem_addr, addr);
      chk("stall_wdata", mem_wdata, data);
      chk("stall_ready", cmd_ready, 1'b0);
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_ready", cmd_ready, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", mem_addr, 2'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_count", count, 3'd0);
    rst_n = 1'b1;
    tick();

    // Two-word program: ITYPE then LW(last)
    do_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_ready", cmd_ready, 1'b1);
    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0);
    chk("t1_we_latency", mem_we, 1'b1);
    write(2'd0, 32'h00500093, 0);
    chk("t1_ready_again", cmd_ready, 1'b1);
    chk("t1_count1", count, 3'd1);
    send(KIND_LW, 5'd2, 5'd1, 5'd0, 3'b000, 7'd0, 32'd8, 1'b1);
    write(2'd1, 32'h0080A103, 0);
    chk("t1_done", done, 1'b1);
    chk("t1_busy_done", busy, 1'b0);
    chk("t1_count2", count, 3'd2);
    tick();
    chk("t1_done_once", done, 1'b0);

    // SW with a 5-cycle grant stall, then RTYPE
    do_start();
    chk("t2_count0", count, 3'd0);
    send(KIND_SW, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4, 1'b0);
    write(2'd0, 32'h0020A223, 5);
    send(KIND_RTYPE, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 1'b1);
    write(2'd1, 32'h002081B3, 0);
    chk("t2_done", done, 1'b1);

    // start together with a valid command: only the start is taken
    cmd_kind = KIND_LW;
    cmd_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_valid = 1'b0;
    chk("t3_busy", busy, 1'b1);
    chk("t3_no_cmd", mem_we, 1'b0);
    send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4, 1'b0);
    write(2'd0, 32'hFE208EE3, 0);
    send(KIND_JAL, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd8, 1'b0);
    write(2'd1, 32'h008000EF, 0);
    send(KIND_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h12345000, 1'b0);
    write(2'd2, 32'h123452B7, 0);
    send(KIND_ITYPE, 5'd1, 5'd1, 5'd0, 3'b001, 7'h20, 32'd3, 1'b1);
    write(2'd3, 32'h40309093, 0);
    chk("t3_done", done, 1'b1);
    chk("t3_count", count, 3'd4);

    // Illegal commands: flagged, nothing written
    do_start();
    send(KIND_BEQ, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 1'b0);
    chk("t4_err_beq", err, 1'b1);
    chk("t4_we_beq", mem_we, 1'b0);
    chk("t4_ready_beq", cmd_ready, 1'b1);
    send(KIND_LUI, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 1'b0);
    chk("t4_we_lui", mem_we, 1'b0);
    send(3'd7, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0);
    chk("t4_we_kind7", mem_we, 1'b0);
    chk("t4_count0", count, 3'd0);
    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b1);
    write(2'd0, 32'h00500093, 0);
    chk("t4_done", done, 1'b1);
    chk("t4_err_sticky", err, 1'b1);
    chk("t4_count1", count, 3'd1);
    tick();
    chk("t4_err_idle", err, 1'b1);
    do_start();
    chk("t4_err_clear", err, 1'b0);
    send(3'd7, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0, 1'b1);
    chk("t4_ill_last_err", err, 1'b1);
    chk("t4_ill_last_done", done, 1'b1);
    chk("t4_ill_last_busy", busy, 1'b0);

    // Memory full: four writes, fifth legal command dropped
    do_start();
    for (int i = 0; i < 4; i++) begin
      send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'(i), 1'b0);
      write(AW'(i), (32'(i) << 20) | 32'h00000093, 0);
    end
    chk("t5_count_full", count, 3'd4);
    chk("t5_addr_wrap", mem_addr, 2'd0);
    chk("t5_err_before", err, 1'b0);
    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd9, 1'b1);
    chk("t5_drop_we", mem_we, 1'b0);
    chk("t5_drop_err", err, 1'b1);
    chk("t5_drop_done", done, 1'b1);
    chk("t5_drop_count", count, 3'd4);

    // Asynchronous reset in the middle of a write
    do_start();
    send(KIND_ITYPE, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 1'b0);
    chk("t6_we_before", mem_we, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we_async", mem_we, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_ready", cmd_ready, 1'b0);
    chk("t6_addr", mem_addr, 2'd0);
    chk("t6_wdata", mem_wdata, 32'd0);
    chk("t6_count", count, 3'd0);
    chk("t6_err", err, 1'b0);
    chk("t6_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_idle", busy, 1'b0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
